constraint_eval_sched: RTL

CONSTRAINT_EVAL_SCHED -- requirements
Module: constraint_eval_sched

---
 rtl/cosmos_sched_pkg.sv | 16 +
 rtl/sat_counter.sv | 30 +++
 rtl/constraint_eval_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cosmos_sched_pkg.sv
// Shared types and helpers for the constraint evaluation scheduler.
package cosmos_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SCAN,
        ST_RESP
    } sched_state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/constraint_eval_sched.sv
// Registers a candidate for external constraint checkers, scans their verdict
// bits one per cycle and reports the first failing index or an overall pass.
module constraint_eval_sched
    import cosmos_sched_pkg::*;
#(
    parameter int NUM_CONS = 16,
    parameter int CAND_W   = 55,
    parameter int SETTLE   = 1,
    parameter int CNT_W    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cand_valid,
    output logic                             cand_ready,
    input  logic [CAND_W-1:0]                cand_data,
    output logic [CAND_W-1:0]                eval_data,
    input  logic [NUM_CONS-1:0]              cons_ok,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic                             res_pass,
    output logic [cnt_width(NUM_CONS)-1:0]   res_fail_idx,
    output logic [CNT_W-1:0]                 pass_count,
    output logic [CNT_W-1:0]                 fail_count
);

    localparam int IDX_W = cnt_width(NUM_CONS);
    localparam int SET_W = cnt_width(SETTLE + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CONS - 1);
    localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE);

    sched_state_e      state_q, state_d;
    logic [CAND_W-1:0] eval_q, eval_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic              pass_q, pass_d;
    logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
    logic              res_hs;

    always_comb begin
        state_d    = state_q;
        eval_d     = eval_q;
        idx_d      = idx_q;
        settle_d   = settle_q;
        pass_d     = pass_q;
        fail_idx_d = fail_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (cand_valid) begin
                    eval_d   = cand_data;
                    idx_d    = '0;
                    settle_d = SETTLE_LD;
                    state_d  = (SETTLE == 0) ? ST_SCAN : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Counter holds the cycles still to spend, including this one.
                settle_d = settle_q - SET_W'(1);
                if (settle_q <= SET_W'(1)) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!cons_ok[idx_q]) begin
                    pass_d     = 1'b0;
                    fail_idx_d = idx_q;
                    state_d    = ST_RESP;
                end else if (idx_q == LAST_IDX) begin
                    pass_d     = 1'b1;
                    fail_idx_d = '0;
                    state_d    = ST_RESP;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            eval_q     <= '0;
            idx_q      <= '0;
            settle_q   <= '0;
            pass_q     <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            eval_q     <= eval_d;
            idx_q      <= idx_d;
            settle_q   <= settle_d;
            pass_q     <= pass_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    // All outputs come straight from flops; cons_ok only feeds next-state logic.
    assign cand_ready   = (state_q == ST_IDLE);
    assign res_valid    = (state_q == ST_RESP);
    assign eval_data    = eval_q;
    assign res_pass     = pass_q;
    assign res_fail_idx = fail_idx_q;
    assign res_hs       = res_valid && res_ready;

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (res_hs && pass_q),
        .count (pass_count)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (res_hs && !pass_q),
        .count (fail_count)
    );

endmodule
